// File: rtl/fp_divider.sv
// Sequential single-precision divider: restoring division of the 24-bit
// significands, valid/ready handshake on both sides, one operation in flight.
// Zeros are handled as specials; every other encoding is treated as a normal
// number with the hidden bit set. Results are truncated, never rounded.
module fp_divider #(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fp_divider_in_valid,
   output logic        fp_divider_in_ready,
   input  logic [31:0] fp_divider_op_1,
   input  logic [31:0] fp_divider_op_2,
   output logic        fp_divider_out_valid,
   input  logic        fp_divider_out_ready,
   output logic [31:0] fp_divider_out
);

   typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

   localparam int N_CYCLES = 25 / BITS_PER_CYCLE;
   localparam logic [4:0] LAST_CNT = 5'(N_CYCLES - 1);

   state_t state, next_state;

   logic        accept, op1_zero, op2_zero, special;
   logic [31:0] special_result;
   logic        sign_q;
   logic [7:0]  exp_a, exp_b;
   logic [23:0] div_b;
   logic [25:0] rem, rem_next;
   logic [24:0] quot, quot_next;
   logic [4:0]  cnt;
   logic [31:0] out_reg;
   logic        adj;
   logic [22:0] norm_frac;
   logic signed [9:0] norm_exp;
   logic [31:0] norm_result;

   assign accept   = fp_divider_in_valid && (state == IDLE);
   assign op1_zero = (fp_divider_op_1[30:0] == 31'h0);
   assign op2_zero = (fp_divider_op_2[30:0] == 31'h0);
   assign special  = op1_zero || op2_zero;

   assign fp_divider_in_ready  = (state == IDLE);
   assign fp_divider_out_valid = (state == DONE);
   assign fp_divider_out       = out_reg;

   // Results for zero operands, decided directly from the incoming operands
   always_comb begin
      special_result = 32'h0;
      if (op2_zero && op1_zero)
         special_result = 32'h7FC00000;
      else if (op2_zero)
         special_result = {fp_divider_op_1[31] ^ fp_divider_op_2[31], 8'hFF, 23'h0};
      else
         special_result = {fp_divider_op_1[31] ^ fp_divider_op_2[31], 31'h0};
   end

   // Resolve BITS_PER_CYCLE quotient bits per cycle, MSB first, restoring style
   always_comb begin
      rem_next  = rem;
      quot_next = quot;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (rem_next >= {2'b00, div_b}) begin
            quot_next = {quot_next[23:0], 1'b1};
            rem_next  = rem_next - {2'b00, div_b};
         end else begin
            quot_next = {quot_next[23:0], 1'b0};
         end
         rem_next = {rem_next[24:0], 1'b0};
      end
   end

   // Normalise the quotient and clamp the exponent to zero or infinity
   always_comb begin
      adj       = ~quot[24];
      norm_frac = quot[24] ? quot[23:1] : quot[22:0];
      norm_exp  = {2'b00, exp_a} - {2'b00, exp_b} + 10'd127 - {9'd0, adj};
      if (norm_exp <= 10'sd0)
         norm_result = {sign_q, 31'h0};
      else if (norm_exp >= 10'sd255)
         norm_result = {sign_q, 8'hFF, 23'h0};
      else
         norm_result = {sign_q, norm_exp[7:0], norm_frac};
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic: zero operands skip the divide loop entirely
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = special ? DONE : DIVIDE;
         DIVIDE:  if (cnt == LAST_CNT) next_state = NORM;
         NORM:    next_state = DONE;
         DONE:    if (fp_divider_out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Datapath registers: capture at accept, iterate, then latch the result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign_q  <= 1'b0;
         exp_a   <= 8'h0;
         exp_b   <= 8'h0;
         div_b   <= 24'h0;
         rem     <= 26'h0;
         quot    <= 25'h0;
         cnt     <= 5'h0;
         out_reg <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  sign_q <= fp_divider_op_1[31] ^ fp_divider_op_2[31];
                  exp_a  <= fp_divider_op_1[30:23];
                  exp_b  <= fp_divider_op_2[30:23];
                  div_b  <= {1'b1, fp_divider_op_2[22:0]};
                  rem    <= {3'b001, fp_divider_op_1[22:0]};
                  quot   <= 25'h0;
                  cnt    <= 5'h0;
                  if (special)
                     out_reg <= special_result;
               end
            end
            DIVIDE: begin
               rem  <= rem_next;
               quot <= quot_next;
               cnt  <= cnt + 5'd1;
            end
            NORM:    out_reg <= norm_result;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_fp_divider;

   localparam int BPC = 1;
   localparam int LAT = 25 / BPC + 2;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] op_1;
   logic [31:0] op_2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;

   int checks   = 0;
   int failures = 0;

   fp_divider #(.BITS_PER_CYCLE(BPC)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .fp_divider_in_valid  (in_valid),
      .fp_divider_in_ready  (in_ready),
      .fp_divider_op_1      (op_1),
      .fp_divider_op_2      (op_2),
      .fp_divider_out_valid (out_valid),
      .fp_divider_out_ready (out_ready),
      .fp_divider_out       (result)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic is_special(input logic [31:0] a, input logic [31:0] b);
      return (a[30:0] == 31'h0) || (b[30:0] == 31'h0);
   endfunction

   // Reference model: exact integer quotient of the significands, then truncate
   function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      longint      ma, mb, q;
      int          e, adj;
      logic [22:0] frac;
      s = a[31] ^ b[31];
      if (a[30:0] == 31'h0 && b[30:0] == 31'h0) return 32'h7FC00000;
      if (b[30:0] == 31'h0) return {s, 8'hFF, 23'h0};
      if (a[30:0] == 31'h0) return {s, 31'h0};
      ma = 64'h800000 + longint'(a[22:0]);
      mb = 64'h800000 + longint'(b[22:0]);
      q  = (ma * 64'd16777216) / mb;
      if (q >= 64'd16777216) begin
         frac = 23'((q / 2) % 64'd8388608);
         adj  = 0;
      end else begin
         frac = 23'(q % 64'd8388608);
         adj  = 1;
      end
      e = int'(a[30:23]) - int'(b[30:23]) + 127 - adj;
      if (e <= 0) return {s, 31'h0};
      if (e >= 255) return {s, 8'hFF, 23'h0};
      return {s, 8'(e), frac};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   // Present one operand pair and let the next rising edge accept it
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input string tag);
      checkOutput({tag, "_in_ready"}, {31'h0, in_ready}, 32'h1);
      in_valid = 1'b1;
      op_1     = a;
      op_2     = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op_1     = $urandom;
      op_2     = $urandom;
   endtask

   // Full transaction: issue, wait for result, optional backpressure, hand off
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag, input int hold);
      logic [31:0] expv;
      int          cyc, explat;
      expv   = model_div(a, b);
      explat = is_special(a, b) ? 1 : LAT;
      applyStimulus(a, b, tag);
      cyc = 1;
      while (out_valid !== 1'b1 && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checkOutput({tag, "_latency"}, 32'(cyc), 32'(explat));
      checkOutput(tag, result, expv);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         op_1     = $urandom;
         op_2     = $urandom;
         @(posedge clk);
         #1;
         checkOutput({tag, "_hold_out"}, result, expv);
         checkOutput({tag, "_hold_valid"}, {31'h0, out_valid}, 32'h1);
         checkOutput({tag, "_hold_in_ready"}, {31'h0, in_ready}, 32'h0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput({tag, "_handoff_valid"}, {31'h0, out_valid}, 32'h0);
      checkOutput({tag, "_handoff_in_ready"}, {31'h0, in_ready}, 32'h1);
      checkOutput({tag, "_handoff_out"}, result, expv);
   endtask

   // Random operand with exponent mostly in a range that avoids clamping
   function automatic logic [31:0] rand_op();
      logic [7:0] e;
      e = 8'($urandom_range(190, 64));
      return {1'($urandom), e, 23'($urandom)};
   endfunction

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op_1      = 32'h0;
      op_2      = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_in_ready", {31'h0, in_ready}, 32'h1);
      checkOutput("reset_out_valid", {31'h0, out_valid}, 32'h0);
      checkOutput("reset_out", result, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] directed cases");
      run_op(32'h40C00000, 32'h40000000, "six_div_two", 0);
      run_op(32'h3F800000, 32'h40400000, "one_div_three", 0);
      run_op(32'hC0F00000, 32'h3F000000, "neg_7p5_div_0p5", 0);
      run_op(32'hBF800000, 32'h00000000, "div_by_zero", 0);
      run_op(32'h00000000, 32'h00000000, "zero_div_zero", 0);
      run_op(32'h00000000, 32'hC0000000, "zero_div_neg", 0);
      run_op(32'h00800000, 32'h7F000000, "underflow", 0);
      run_op(32'h7F000000, 32'h3E800000, "overflow", 0);

      $display("[TB] backpressure");
      run_op(32'h41200000, 32'h40800000, "backpressure", 10);

      $display("[TB] random operands");
      for (int i = 0; i < 20; i++)
         run_op(rand_op(), rand_op(), $sformatf("rand%0d", i), 0);
      for (int i = 0; i < 4; i++)
         run_op($urandom, $urandom, $sformatf("rand_full%0d", i), 0);

      $display("[TB] reset during divide");
      run_op(32'h40C00000, 32'h40000000, "pre_reset", 0);
      applyStimulus(32'h3F800000, 32'h40400000, "abandoned");
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_out_valid", {31'h0, out_valid}, 32'h0);
      checkOutput("midreset_out", result, 32'h0);
      checkOutput("midreset_in_ready", {31'h0, in_ready}, 32'h1);
      #20;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post_reset_out_valid", {31'h0, out_valid}, 32'h0);
      run_op(32'hC0F00000, 32'h3F000000, "after_reset", 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
